// File: rtl/v8cpu_uart.sv
// Memory-mapped UART for the v8cpu data bus: 4-byte register window with a
// TX FIFO, TX shifter, RX sampler and a programmable baud divisor.
module v8cpu_uart #(
  parameter logic [15:0] BASE_ADDR      = 16'h0810,
  parameter logic [7:0]  BAUD_DIV_RESET = 8'd68,
  parameter int unsigned TX_FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_en,
  input  logic        we,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  output logic [7:0]  q,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(TX_FIFO_DEPTH);

  localparam logic [1:0] OFS_TXDATA  = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_RXDATA  = 2'd2;
  localparam logic [1:0] OFS_BAUDDIV = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             mapped;
  logic [1:0]       ofs;
  logic             rd_stb;
  logic             wr_stb;
  logic             rd_status;
  logic             rd_rxdata;

  logic [7:0]       q_reg;
  logic [7:0]       baud_div;
  logic [7:0]       status;

  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;

  state_t           tx_state;
  logic [7:0]       tx_cnt;
  logic [7:0]       tx_shift;
  logic [2:0]       tx_bit;
  logic             tx_busy;

  state_t           rx_state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [7:0]       rx_cnt;
  logic [7:0]       rx_shift;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_hold;
  logic             rx_valid;
  logic             rx_overrun;
  logic             rx_frame_err;
  logic [7:0]       rx_half;
  logic [7:0]       rx_half_load;

  // Address decode: the low two bits select the register inside the window.
  assign mapped    = (address[15:2] == BASE_ADDR[15:2]);
  assign ofs       = address[1:0];
  assign rd_stb    = bus_en & ~we & mapped;
  assign wr_stb    = bus_en & we & mapped;
  assign rd_status = rd_stb & (ofs == OFS_STATUS);
  assign rd_rxdata = rd_stb & (ofs == OFS_RXDATA);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = wr_stb & (ofs == OFS_TXDATA) & ~fifo_full;

  assign tx_busy = (tx_state != S_IDLE);
  assign status  = {2'b00, rx_frame_err, rx_overrun, rx_valid, tx_busy, fifo_empty, fifo_full};

  assign q   = mapped ? q_reg : 8'bzzzz_zzzz;
  assign irq = rx_valid | (fifo_empty & ~tx_busy);

  // Sample point sits half a bit into the start bit; the detect cycle counts as one.
  assign rx_half      = 8'((9'(baud_div) + 9'd1) >> 1);
  assign rx_half_load = (rx_half == 8'd0) ? 8'd0 : rx_half - 8'd1;

  // Bus side: read capture register and baud divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg    <= 8'd0;
      baud_div <= BAUD_DIV_RESET;
    end else begin
      if (rd_stb) begin
        case (ofs)
          OFS_TXDATA:  q_reg <= 8'd0;
          OFS_STATUS:  q_reg <= status;
          OFS_RXDATA:  q_reg <= rx_hold;
          default:     q_reg <= baud_div;
        endcase
      end
      if (wr_stb && (ofs == OFS_BAUDDIV)) begin
        baud_div <= data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + (PTR_W+1)'(1);
    end
  end

  // TX FSM; owns the FIFO read pointer so a pop always coincides with a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= 8'd0;
      tx_shift <= 8'd0;
      tx_bit   <= 3'd0;
      rd_ptr   <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            tx_shift <= fifo_mem[rd_ptr[PTR_W-1:0]];
            rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
            tx_cnt   <= baud_div;
            tx       <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == 8'd0) begin
            tx_cnt   <= baud_div;
            tx_bit   <= 3'd0;
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == 8'd0) begin
            tx_cnt <= baud_div;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt == 8'd0) begin
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // RX synchronizer, FSM and status flags; frame completion wins over read clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= 8'd0;
      rx_shift     <= 8'd0;
      rx_bit       <= 3'd0;
      rx_hold      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end
      if (rd_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end

      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= rx_half_load;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == 8'd0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_cnt   <= baud_div;
              rx_bit   <= 3'd0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == 8'd0) begin
            rx_cnt   <= baud_div;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt == 8'd0) begin
            rx_state <= S_IDLE;
            if (rx_s2) begin
              rx_hold  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rd_rxdata) begin
                rx_overrun <= 1'b1;
              end
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v8cpu_uart.sv
// Directed bench for v8cpu_uart: register access, TX framing and FIFO,
// RX reception with overrun/frame error/glitch, and mid-frame reset.
module tb_v8cpu_uart;

  localparam logic [15:0] A_TX  = 16'h0810;
  localparam logic [15:0] A_ST  = 16'h0811;
  localparam logic [15:0] A_RX  = 16'h0812;
  localparam logic [15:0] A_BD  = 16'h0813;
  localparam logic [15:0] A_OFF = 16'h0800;

  logic        clk;
  logic        reset;
  logic        bus_en;
  logic        we;
  logic [15:0] address;
  logic [7:0]  data;
  wire  [7:0]  q;
  logic        tx;
  logic        rx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] v;
  logic [7:0] st_full;
  logic [7:0] st_ff;
  logic [7:0] rxb [5];
  logic       rok [5];
  logic [9:0] a5_frame;
  int         lows;

  v8cpu_uart dut (
    .clk     (clk),
    .reset   (reset),
    .bus_en  (bus_en),
    .we      (we),
    .address (address),
    .data    (data),
    .q       (q),
    .tx      (tx),
    .rx      (rx),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_en = 1'b1; we = 1'b1; address = a; data = d;
    @(negedge clk);
    bus_en = 1'b0; we = 1'b0;
  endtask

  // Data is sampled one cycle after the strobe, with the address still applied.
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_en = 1'b1; we = 1'b0; address = a;
    @(negedge clk);
    bus_en = 1'b0;
    d = q;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (4) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Decodes one 4-clk/bit frame from tx, sampling mid-bit.
  task automatic get_byte(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    b = 8'd0;
    ok = 1'b0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (4) @(negedge clk);
        b[j] = tx;
      end
      repeat (4) @(negedge clk);
      ok = (tx === 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus_en = 1'b0; we = 1'b0; address = A_OFF; data = 8'd0; rx = 1'b1;
    a5_frame = {1'b1, 8'hA5, 1'b0};
    repeat (2) @(negedge clk);
    check1("rst_tx", tx, 1'b1);
    check1("rst_irq", irq, 1'b1);
    checks++;
    assert (q === 8'bzzzz_zzzz) else begin
      errors++;
      $error("FAIL rst_q_z observed=%h expected=zz", q);
    end
    reset = 1'b0;
    @(negedge clk);
    address = A_TX;
    #1;
    check8("rst_qreg", q, 8'h00);

    bus_read(A_ST, v);  check8("rst_status", v, 8'h02);
    bus_read(A_BD, v);  check8("rst_baud", v, 8'd68);
    bus_read(A_TX, v);  check8("txdata_read", v, 8'h00);
    bus_write(A_ST, 8'hFF);
    bus_read(A_ST, v);  check8("status_wr_ignored", v, 8'h02);
    bus_write(A_BD, 8'd3);
    bus_read(A_BD, v);  check8("baud_rw", v, 8'd3);

    // Single A5 frame: 10 bits of exactly 4 clks each.
    bus_write(A_TX, 8'hA5);
    check1("tx_pre_start", tx, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check1($sformatf("tx_a5_c%0d", i), tx, a5_frame[i/4]);
    end
    @(negedge clk);
    check1("tx_after_stop", tx, 1'b1);
    bus_read(A_ST, v);  check8("status_after_frame", v, 8'h02);

    bus_write(A_TX, 8'hA5);
    repeat (2) @(negedge clk);
    bus_read(A_ST, v);  check8("status_busy", v, 8'h06);
    check1("irq_busy", irq, 1'b0);
    repeat (50) @(negedge clk);
    bus_read(A_ST, v);  check8("status_idle", v, 8'h02);

    // Five back-to-back writes fill the FIFO; the sixth is dropped.
    fork
      begin
        for (int k = 0; k < 5; k++) get_byte(rxb[k], rok[k]);
      end
      begin
        @(negedge clk);
        bus_en = 1'b1; we = 1'b1; address = A_TX;
        for (int k = 1; k <= 5; k++) begin
          data = 8'(k);
          @(negedge clk);
        end
        bus_en = 1'b0; we = 1'b0;
        bus_read(A_ST, st_full);
        bus_write(A_TX, 8'hFF);
        bus_read(A_ST, st_ff);
      end
    join
    check8("status_full", st_full, 8'h05);
    check8("status_after_drop", st_ff, 8'h05);
    for (int k = 0; k < 5; k++) begin
      check8($sformatf("fifo_byte%0d", k), rxb[k], 8'(k + 1));
      check1($sformatf("fifo_stop%0d", k), rok[k], 1'b1);
    end
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check8("no_ff_frame", 8'(lows), 8'd0);
    bus_read(A_ST, v);  check8("status_fifo_drained", v, 8'h02);

    // RX single byte.
    send_rx(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    check1("irq_rx", irq, 1'b1);
    bus_read(A_ST, v);  check8("status_rx_valid", v, 8'h0A);
    bus_read(A_RX, v);  check8("rxdata_3c", v, 8'h3C);
    bus_read(A_ST, v);  check8("status_rx_cleared", v, 8'h02);

    // Overrun.
    send_rx(8'h11, 1'b1);
    repeat (3) @(negedge clk);
    send_rx(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    bus_read(A_ST, v);  check8("status_overrun", v, 8'h1A);
    bus_read(A_RX, v);  check8("rxdata_22", v, 8'h22);
    bus_read(A_ST, v);  check8("status_overrun_clr", v, 8'h02);

    // Frame error leaves rx_valid alone.
    send_rx(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    bus_read(A_ST, v);  check8("status_frame_err", v, 8'h22);
    bus_read(A_ST, v);  check8("status_frame_err_clr", v, 8'h02);

    // One-clock low glitch.
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (50) @(negedge clk);
    bus_read(A_ST, v);  check8("status_glitch", v, 8'h02);

    // Reset in the middle of data bit 3 of A5.
    bus_write(A_TX, 8'hA5);
    repeat (19) @(negedge clk);
    check1("tx_mid_bit3", tx, 1'b0);
    #2 reset = 1'b1;
    #1 check1("tx_async_reset", tx, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check1("tx_after_reset", tx, 1'b1);
    bus_read(A_ST, v);  check8("status_after_reset", v, 8'h02);
    bus_read(A_BD, v);  check8("baud_after_reset", v, 8'd68);
    address = A_OFF;
    #1;
    checks++;
    assert (q === 8'bzzzz_zzzz) else begin
      errors++;
      $error("FAIL q_unmapped observed=%h expected=zz", q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/v8cpu_uart.md
Name: v8cpu_uart

Overview:
- Memory-mapped UART peripheral on the v8cpu data bus, alongside the port/pin I/O block.
- Consumes CPU store cycles to transmit serial bytes and supplies load data from a receive holding register.
- Contains a 4-entry TX FIFO, a TX shifter, an RX sampler and a programmable baud divisor.
- Drives the shared memQ read bus only when one of its own addresses is selected.

Parameters:
- BASE_ADDR, 16'h0810, base of the 4-byte register window (bits [1:0] must be 0).
- BAUD_DIV_RESET, 8'd68, reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles.
- TX_FIFO_DEPTH, 4, TX FIFO entries (power of 2; pointers are log2(depth) bits plus a wrap bit).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_en  in  1  one-cycle access strobe (bus memClk pulse qualified into the clk domain).
- we  in  1  1 = write access, 0 = read access; sampled only when bus_en=1.
- address  in  16  bus address.
- data  in  8  write data.
- q  out  8  read data; 8'bZZZZZZZZ unless address is in BASE_ADDR..BASE_ADDR+3.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous to clk.
- irq  out  1  level-high interrupt: rx_valid OR (tx FIFO empty AND tx idle).

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0 TXDATA: a write pushes to the TX FIFO; a read returns 0.
  - +1 STATUS (read-only): bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 rx_valid, bit4 rx_overrun, bit5 rx_frame_err; bits7:6 read 0.
  - +2 RXDATA: a read returns the held byte and clears rx_valid.
  - +3 BAUDDIV: read/write.
- Read timing:
  - On clk with bus_en=1, we=0 and a mapped address, q_reg <= selected value.
  - q = q_reg combinationally while the address stays mapped.
  - Data is therefore valid one cycle after the strobe.
- Side effects occur only on the strobe cycle:
  - A RXDATA read clears rx_valid.
  - A STATUS read clears rx_overrun and rx_frame_err.
  - Both flags are cleared after their value has been captured into q_reg.
- Writes to unmapped addresses or to STATUS are ignored. A write to TXDATA while full is dropped, with no state change.
- Reset values:
  - tx=1, q_reg=0, FIFO empty (pointers 0), TX FSM=IDLE, RX FSM=IDLE.
  - rx_valid=0, rx_overrun=0, rx_frame_err=0, rx holding register=0.
  - BAUDDIV=BAUD_DIV_RESET, irq=1 (FIFO empty and TX idle).
- Reset asserted mid-frame aborts immediately. tx returns to 1 asynchronously and the partial frame is lost.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into the shifter and go to START in the same cycle; tx stays 1 during that cycle.
  - START: tx=0 for BAUDDIV+1 cycles. DATA: 8 bits, LSB first, each BAUDDIV+1 cycles. STOP: tx=1 for BAUDDIV+1 cycles.
  - After STOP, go to IDLE. A non-empty FIFO starts the next frame on the following cycle, giving a 1-cycle extra idle gap.
  - tx_busy = (state != IDLE).
  - The bit counter is 3 bits. The baud counter is 8 bits, counts down from BAUDDIV and reloads on reaching 0.
- BAUDDIV write while a frame is in progress takes effect at the next bit boundary reload. BAUDDIV=0 gives 1 clk per bit; this is legal for TX only.
- FIFO push and pop in the same cycle leave the count unchanged; both occur. Pointers wrap modulo depth. full/empty derive from the wrap bit.
- RX path:
  - rx passes through a 2-flop synchronizer, which adds 2 cycles of latency.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized 1->0 transition starts a (BAUDDIV+1)/2 half-bit wait (integer divide), then samples.
  - If the sample is 1 (glitch), return to IDLE. Otherwise sample 8 data bits at full-bit intervals, LSB first, then the stop bit.
  - Stop=1: load the holding register and set rx_valid. If rx_valid was already 1, also set rx_overrun; the new byte overwrites the old one.
  - Stop=0: discard the byte, set rx_frame_err, and leave rx_valid unchanged.
  - If an RXDATA read strobe and frame completion occur in the same cycle, the read returns the old byte, the new byte is loaded, rx_valid stays 1 and rx_overrun is not set.
- irq is combinational from registered flags.

Test Plan:
- BAUDDIV=3. Write TXDATA=8'hA5 -> tx shows start(0), bits 1,0,1,0,0,1,0,1, stop(1), each exactly 4 clks, for 40 clks total. STATUS bit2 reads 1 during the frame and 0 after.
- Write 5 bytes 8'h01..8'h05 back-to-back while TX is idle -> the first is popped immediately. The remaining 4 fill the FIFO, so STATUS.bit0=1 after the 5th write. A 6th write of 8'hFF is dropped. The line shows 01..05 in order with no FF.
- Drive a 4-clk/bit frame of 8'h3C on rx -> rx_valid=1 and irq=1. An RXDATA read returns 8'h3C one cycle after the strobe and clears rx_valid. STATUS then reads 8'h02 with the FIFO empty and TX idle.
- Receive 8'h11 then 8'h22 without reading -> STATUS=8'h1A (overrun set). RXDATA reads 8'h22. A second STATUS read shows bit4=0.
- Receive a frame with stop bit 0 -> rx_valid unchanged and STATUS bit5=1. Also drive a 1-clk low glitch on rx -> no frame and no flags.
- Assert reset mid-TX at bit 3 of 8'hA5 -> tx=1 asynchronously. After release, STATUS=8'h02, BAUDDIV reads 8'd68, and q=Z for address 16'h0800.
